// File: rtl/setpoint_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : setpoint_debounce / setpoint_control                          |
// | Brief    : Five-button operator setpoint controller with debounce,       |
// |            press/hold/auto-repeat sequencing and saturating x/y targets. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module setpoint_debounce #(
  parameter int DELAY = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam logic [19:0] c_LAST = 20'(DELAY - 1);

  logic        r_sync;
  logic        r_clean;
  logic [19:0] r_cnt;

  // Sample the raw pin, then let clean follow once the sample has been stable
  // and different from clean for DELAY consecutive cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync  <= raw;
      r_clean <= raw;
      r_cnt   <= '0;
    end else begin
      r_sync <= raw;
      if (r_sync == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
        r_clean <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

  assign clean = r_clean;

endmodule

module setpoint_control #(
  parameter int DEBOUNCE_DELAY = 1000000,
  parameter int HOLD_DELAY     = 50000000,
  parameter int REPEAT_PERIOD  = 10000000,
  parameter int STEP           = 4,
  parameter int X_MAX          = 1023,
  parameter int Y_MAX          = 767,
  parameter int CENTER_X       = 512,
  parameter int CENTER_Y       = 384
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_center,
  output logic [9:0] target_x,
  output logic [9:0] target_y,
  output logic       update,
  output logic       repeating
);

  // Button indices into the debounced vectors; lower index wins on ties.
  localparam logic [2:0] c_BTN_C = 3'd0;
  localparam logic [2:0] c_BTN_U = 3'd1;
  localparam logic [2:0] c_BTN_D = 3'd2;
  localparam logic [2:0] c_BTN_R = 3'd3;
  localparam logic [2:0] c_BTN_L = 3'd4;

  localparam logic [10:0] c_STEP      = 11'(STEP);
  localparam logic [9:0]  c_STEP10    = 10'(STEP);
  localparam logic [9:0]  c_XMAX      = 10'(X_MAX);
  localparam logic [9:0]  c_YMAX      = 10'(Y_MAX);
  localparam logic [9:0]  c_CX        = 10'(CENTER_X);
  localparam logic [9:0]  c_CY        = 10'(CENTER_Y);
  localparam logic [31:0] c_HOLD_LAST = 32'(HOLD_DELAY - 1);
  localparam logic [31:0] c_REP_LAST  = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  logic [4:0]  w_raw;
  logic [4:0]  w_clean;
  logic [4:0]  w_press;
  logic [4:0]  r_prev;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_active;
  logic [2:0]  w_active_nxt;
  logic [2:0]  w_win;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic        w_do_step;
  logic [2:0]  w_step_btn;
  logic [9:0]  r_tx;
  logic [9:0]  r_ty;
  logic [9:0]  r_last_x;
  logic [9:0]  r_last_y;
  logic        r_update;

  // Saturating increment computed in 11 bits so the sum cannot wrap.
  function automatic logic [9:0] f_inc(input logic [9:0] v, input logic [9:0] mx);
    logic [10:0] s;
    s = {1'b0, v} + c_STEP;
    return (s > {1'b0, mx}) ? mx : s[9:0];
  endfunction

  // Decrement clamped at zero.
  function automatic logic [9:0] f_dec(input logic [9:0] v);
    return (v < c_STEP10) ? 10'd0 : (v - c_STEP10);
  endfunction

  assign w_raw = {btn_left, btn_right, btn_down, btn_up, btn_center};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_debounce
      setpoint_debounce #(
        .DELAY (DEBOUNCE_DELAY)
      ) u_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (w_raw[gi]),
        .clean (w_clean[gi])
      );
    end
  endgenerate

  assign w_press = w_clean & ~r_prev;

  // Previous-clean history; reset to ones so buttons held through reset are ignored.
  always_ff @(posedge clock) begin
    if (reset) r_prev <= 5'h1F;
    else       r_prev <= w_clean;
  end

  // Priority pick among new presses: center > up > down > right > left.
  always_comb begin
    w_win = c_BTN_L;
    if (w_press[0])      w_win = c_BTN_C;
    else if (w_press[1]) w_win = c_BTN_U;
    else if (w_press[2]) w_win = c_BTN_D;
    else if (w_press[3]) w_win = c_BTN_R;
  end

  // FSM state, owner and hold/repeat counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_active <= c_BTN_C;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Next-state logic and step requests for the single owned button.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_cnt_nxt    = r_cnt;
    w_do_step    = 1'b0;
    w_step_btn   = r_active;
    case (r_state)
      S_IDLE: begin
        if (|w_press) begin
          w_active_nxt = w_win;
          w_step_btn   = w_win;
          w_do_step    = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = (w_win == c_BTN_C) ? S_HOLD : S_PRESSED;
        end
      end
      S_PRESSED: begin
        w_cnt_nxt = r_cnt + 32'd1;
        if (!w_clean[r_active]) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_HOLD_LAST) begin
          w_do_step   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_REPEAT;
        end
      end
      S_REPEAT: begin
        w_cnt_nxt = r_cnt + 32'd1;
        if (!w_clean[r_active]) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_REP_LAST) begin
          w_do_step = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      S_HOLD: begin
        if (!w_clean[c_BTN_C]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Setpoint register: apply the requested step with saturation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx <= c_CX;
      r_ty <= c_CY;
    end else if (w_do_step) begin
      case (w_step_btn)
        c_BTN_C: begin
          r_tx <= c_CX;
          r_ty <= c_CY;
        end
        c_BTN_U: r_ty <= f_inc(r_ty, c_YMAX);
        c_BTN_D: r_ty <= f_dec(r_ty);
        c_BTN_R: r_tx <= f_inc(r_tx, c_XMAX);
        c_BTN_L: r_tx <= f_dec(r_tx);
        default: ;
      endcase
    end
  end

  // Pulse update the cycle after the visible setpoint actually changed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_x <= c_CX;
      r_last_y <= c_CY;
      r_update <= 1'b0;
    end else begin
      r_last_x <= r_tx;
      r_last_y <= r_ty;
      r_update <= (r_tx != r_last_x) || (r_ty != r_last_y);
    end
  end

  assign target_x  = r_tx;
  assign target_y  = r_ty;
  assign update    = r_update;
  assign repeating = (r_state == S_REPEAT);

endmodule
`default_nettype wire
